execute_stage: RTL
==================

Name: execute_stage

Overview:
- Execute stage of the 8-bit pipeline. It sits directly downstream of decode and consumes decode's flopped register operands, memory/jump controls and the forwarded instruction byte.
- Computes the ALU result, memory address and store data, register write-back control, and jump resolution.
- Single-cycle ops complete through one output register. MUL is an iterative shift-add FSM that stalls upstream while it runs.

Parameters:
- WIDTH, 8, datapath width. Only 8 is supported.
- ENABLE_MUL, 1, when 1 R-type funct 11 is an iterative MUL. When 0, funct 11 is a single-cycle OR and stall_out is tied low.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  decode outputs hold a real instruction.
- instr_in  in  8  instruction byte: [7:6] opcode, [5:4] rs/subop, [3:2] rt, [1:0] imm/funct.
- read_data_1_in  in  8  reg[rs].
- read_data_2_in  in  8  reg[rt].
- MemtoReg_in  in  1  load result selects memory data.
- MemRead_in  in  1  load.
- MemWrite_in  in  1  store.
- PCSrc_in  in  1  jump.
- stall_out  out  1  high while MUL is busy; upstream must hold all inputs stable.
- valid_out  out  1  outputs below carry a completed instruction.
- alu_result_out  out  8  ALU result or memory address.
- store_data_out  out  8  store data.
- write_reg_out  out  2  destination register (always rt).
- RegWrite_out  out  1  write-back enable.
- MemtoReg_out  out  1  registered copy of MemtoReg_in.
- MemRead_out  out  1  registered copy of MemRead_in.
- MemWrite_out  out  1  registered copy of MemWrite_in.
- branch_taken_out  out  1  one-cycle pulse; a JMP completed.
- branch_target_out  out  8  jump target.
- zero_out  out  1  alu_result_out == 0.

Behaviour:
- Reset: every output is 0, FSM is IDLE, multiply counter and accumulators are cleared. Reset asserted mid-MUL aborts the multiply; no valid_out is produced for it.
- Accept: an instruction is accepted on a rising edge when valid_in=1 and state=IDLE.
- Single-cycle latency: outputs update on the accepting edge (1 cycle).
- No accept on an edge: valid_out=0, RegWrite_out=0, Mem*_out=0, branch_taken_out=0. Data outputs hold their last values.
- Arithmetic: all results wrap mod 256. imm is zero-extended: {6'b0, instr[1:0]}. A = read_data_1_in, B = read_data_2_in.
- Opcode 00, R-type, destination rt, RegWrite=1:
  - funct 00: ADD, A+B.
  - funct 01: SUB, A-B.
  - funct 10: AND, A&B.
  - funct 11: MUL or OR, per ENABLE_MUL.
- Opcode 01, subop selects the operation:
  - subop 00: ADDI, result B+imm, RegWrite=1.
  - subop 01: LD, address B+imm, RegWrite=1, MemRead=1, MemtoReg=1.
  - subop 10: ST, address imm, store_data_out=B, RegWrite=0, MemWrite=1.
  - subop 11: LI, result imm, RegWrite=1.
- Opcode 10: JMP. branch_target_out={2'b00, instr[5:0]}, branch_taken_out=1 for exactly one cycle, RegWrite=0, alu_result_out=0.
- Opcode 11: NOP. valid_out=1, every enable 0, alu_result_out=0.
- Mem*_out are the registered Mem*_in controls. A mismatch between those inputs and the decoded opcode is not checked.
- MUL FSM, states IDLE and MUL:
  - IDLE→MUL on accept of a MUL: load mcand=A, mplier=B, acc=0, cnt=0. No outputs update on that edge.
  - Each MUL edge: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt++.
  - On the edge where cnt==7: the final acc goes to alu_result_out, valid_out=1, RegWrite_out=1, state→IDLE.
  - Total latency is 9 edges from accept; stall_out is high for exactly the 8 cycles state==MUL.
  - stall_out is a decode of the registered state (no combinational path from inputs).
  - valid_in is ignored while in MUL.
  - The next instruction may be accepted on the edge after MUL completes.
- zero_out is registered with, and reflects, the value loaded into alu_result_out.

Test Plan:
- Reset: assert rst for 3 cycles then release with valid_in=0 → all outputs 0, stall_out=0.
- ADD 0x70+0x95 (instr 0x00, A=0x70, B=0x95) → next edge alu_result_out=0x05, RegWrite_out=1, write_reg_out=0, zero_out=0. SUB 0x33−0x33 → 0x00, zero_out=1.
- LD with rt=2, imm=3, B=0xFE (instr 0x5B) → alu_result_out=0x01, MemRead_out=1, MemtoReg_out=1, write_reg_out=2. ST with imm=2, B=0xAA (instr 0x62) → alu_result_out=0x02, store_data_out=0xAA, MemWrite_out=1, RegWrite_out=0.
- JMP instr 0xA5 → branch_target_out=0x25, branch_taken_out high for exactly 1 cycle. Back-to-back JMPs → two separate pulses.
- MUL A=13, B=11 (instr 0x03) → stall_out high 8 cycles, then alu_result_out=0x8F with valid_out=1 on edge 9. A=0xFF, B=0xFF → 0x01. Next ADD held on inputs is accepted the following edge.
- Assert rst at cycle 4 of a MUL → immediately all outputs 0, stall_out=0, no valid_out for the aborted MUL. A MUL issued after release completes normally.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage of the 8-bit pipeline: ALU, address/store data, write-back control,
// jump resolution, and an optional iterative shift-add multiplier that stalls decode.
module execute_stage #(
    parameter int WIDTH      = 8,
    parameter int ENABLE_MUL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [7:0]       instr_in,
    input  logic [WIDTH-1:0] read_data_1_in,
    input  logic [WIDTH-1:0] read_data_2_in,
    input  logic             MemtoReg_in,
    input  logic             MemRead_in,
    input  logic             MemWrite_in,
    input  logic             PCSrc_in,
    output logic             stall_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] alu_result_out,
    output logic [WIDTH-1:0] store_data_out,
    output logic [1:0]       write_reg_out,
    output logic             RegWrite_out,
    output logic             MemtoReg_out,
    output logic             MemRead_out,
    output logic             MemWrite_out,
    output logic             branch_taken_out,
    output logic [WIDTH-1:0] branch_target_out,
    output logic             zero_out
);

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d, regwrite_q, regwrite_d;
    logic             memtoreg_q, memtoreg_d, memread_q, memread_d, memwrite_q, memwrite_d;
    logic             br_taken_q, br_taken_d, zero_q, zero_d;
    logic [WIDTH-1:0] alu_q, alu_d, store_q, store_d, br_target_q, br_target_d;
    logic [1:0]       wreg_q, wreg_d;

    logic [1:0]       opcode, subop, funct;
    logic [WIDTH-1:0] imm, acc_next;
    logic             is_mul;

    // PCSrc is implied by the JMP opcode; the decode copy is accepted but not needed.
    logic unused_pcsrc;
    assign unused_pcsrc = PCSrc_in;

    assign opcode   = instr_in[7:6];
    assign subop    = instr_in[5:4];
    assign funct    = instr_in[1:0];
    assign imm      = {{(WIDTH-2){1'b0}}, instr_in[1:0]};
    assign is_mul   = (ENABLE_MUL != 0) && (opcode == 2'b00) && (funct == 2'b11);
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    function automatic logic [WIDTH-1:0] alu_op(input logic [1:0] op, input logic [1:0] sub,
                                                input logic [1:0] fn, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] im);
        logic [WIDTH-1:0] r;
        r = '0;
        if (op == 2'b00) begin
            case (fn)
                2'b00:   r = a + b;
                2'b01:   r = a - b;
                2'b10:   r = a & b;
                default: r = a | b;
            endcase
        end else if (op == 2'b01) begin
            case (sub)
                2'b00, 2'b01: r = b + im;
                default:      r = im;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        regwrite_d  = 1'b0;
        memtoreg_d  = 1'b0;
        memread_d   = 1'b0;
        memwrite_d  = 1'b0;
        br_taken_d  = 1'b0;
        alu_d       = alu_q;
        zero_d      = zero_q;
        store_d     = store_q;
        br_target_d = br_target_q;
        wreg_d      = wreg_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (is_mul) begin
                        state_d  = MUL;
                        mcand_d  = read_data_1_in;
                        mplier_d = read_data_2_in;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        valid_d    = 1'b1;
                        wreg_d     = instr_in[3:2];
                        memtoreg_d = MemtoReg_in;
                        memread_d  = MemRead_in;
                        memwrite_d = MemWrite_in;
                        store_d    = read_data_2_in;
                        alu_d      = alu_op(opcode, subop, funct, read_data_1_in, read_data_2_in, imm);
                        zero_d     = (alu_d == '0);
                        regwrite_d = (opcode == 2'b00) || (opcode == 2'b01 && subop != 2'b10);
                        if (opcode == 2'b10) begin
                            br_taken_d  = 1'b1;
                            br_target_d = {2'b00, instr_in[5:0]};
                        end
                    end
                end
            end
            default: begin
                // One shift-add step per edge; the eighth step also retires the result.
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d    = IDLE;
                    alu_d      = acc_next;
                    zero_d     = (acc_next == '0);
                    valid_d    = 1'b1;
                    regwrite_d = 1'b1;
                    wreg_d     = instr_in[3:2];
                    memtoreg_d = MemtoReg_in;
                    memread_d  = MemRead_in;
                    memwrite_d = MemWrite_in;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            br_taken_q  <= 1'b0;
            alu_q       <= '0;
            zero_q      <= 1'b0;
            store_q     <= '0;
            br_target_q <= '0;
            wreg_q      <= '0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            br_taken_q  <= br_taken_d;
            alu_q       <= alu_d;
            zero_q      <= zero_d;
            store_q     <= store_d;
            br_target_q <= br_target_d;
            wreg_q      <= wreg_d;
        end
    end

    assign stall_out         = (ENABLE_MUL != 0) && (state_q == MUL);
    assign valid_out         = valid_q;
    assign alu_result_out    = alu_q;
    assign store_data_out    = store_q;
    assign write_reg_out     = wreg_q;
    assign RegWrite_out      = regwrite_q;
    assign MemtoReg_out      = memtoreg_q;
    assign MemRead_out       = memread_q;
    assign MemWrite_out      = memwrite_q;
    assign branch_taken_out  = br_taken_q;
    assign branch_target_out = br_target_q;
    assign zero_out          = zero_q;

endmodule
